// File: rtl/coef_bank_writer.sv
// Run-time loadable IIR coefficient store: five-beat bursts land in a shadow bank,
// commit atomically to one of three live banks, and reach the datapath only on sample ticks.
//
// state  | meaning
// IDLE   | waiting for the first beat of a burst
// LOAD   | collecting beats 1..4 into the shadow, idx = next slot
// COMMIT | one cycle copying the shadow into the latched live bank
module coef_bank_writer #(
  parameter int WIDTH = 22
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sample_tick,
  input  logic [1:0]       sel,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [1:0]       wr_bank,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_last,
  output logic [WIDTH-1:0] coef_b0,
  output logic [WIDTH-1:0] coef_b1,
  output logic [WIDTH-1:0] coef_b2,
  output logic [WIDTH-1:0] coef_a1,
  output logic [WIDTH-1:0] coef_a2,
  output logic [1:0]       bank_active,
  output logic             busy,
  output logic             load_done,
  output logic             load_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] B0_BANK1 = WIDTH'(22'h003FDF);
  localparam logic [WIDTH-1:0] B0_BANK2 = WIDTH'(22'h004000);
  localparam logic [WIDTH-1:0] B0_BANK3 = WIDTH'(22'h002672);

  state_t           state, state_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [1:0]       bank_lat;
  logic             beat;
  logic             shadow_we;
  logic             latch_bank;
  logic             abort;
  logic [1:0]       commit_idx;
  logic [1:0]       rd_idx;

  logic [WIDTH-1:0] shadow [5];
  logic [WIDTH-1:0] live   [3][5];
  logic [WIDTH-1:0] rd     [5];
  logic [WIDTH-1:0] coef_q [5];

  assign wr_ready   = (state != COMMIT);
  assign busy       = (state != IDLE);
  assign load_done  = (state == COMMIT);
  assign beat       = wr_valid && wr_ready;
  assign commit_idx = bank_lat - 2'd1;
  assign rd_idx     = sel - 2'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      idx      <= 3'd0;
      bank_lat <= 2'd0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      load_err <= abort;
      if (latch_bank) bank_lat <= wr_bank;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    shadow_we  = 1'b0;
    latch_bank = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (beat) begin
          shadow_we = 1'b1;
          if (wr_last) begin
            abort = 1'b1;
          end else begin
            latch_bank = 1'b1;
            idx_nxt    = 3'd1;
            state_nxt  = LOAD;
          end
        end
      end
      LOAD: begin
        if (beat) begin
          shadow_we = 1'b1;
          if (idx == 3'd4) begin
            idx_nxt = 3'd0;
            // bank 0 is not writable: the burst is consumed but never committed
            if (wr_last && (bank_lat != 2'd0)) begin
              state_nxt = COMMIT;
            end else begin
              abort     = 1'b1;
              state_nxt = IDLE;
            end
          end else if (wr_last) begin
            abort     = 1'b1;
            idx_nxt   = 3'd0;
            state_nxt = IDLE;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      COMMIT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 5; k++) shadow[k] <= '0;
    end else if (shadow_we) begin
      shadow[idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 3; b++) begin
        for (int k = 0; k < 5; k++) live[b][k] <= '0;
      end
      live[0][0] <= B0_BANK1;
      live[1][0] <= B0_BANK2;
      live[2][0] <= B0_BANK3;
    end else if (state == COMMIT) begin
      for (int k = 0; k < 5; k++) live[commit_idx][k] <= shadow[k];
    end
  end

  always_comb begin
    for (int k = 0; k < 5; k++) begin
      rd[k] = '0;
      if (sel != 2'd0) rd[k] = live[rd_idx][k];
    end
  end

  // A tick coinciding with COMMIT reads the pre-commit live words, since the copy lands on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_active <= 2'd0;
      for (int k = 0; k < 5; k++) coef_q[k] <= '0;
    end else if (sample_tick) begin
      bank_active <= sel;
      for (int k = 0; k < 5; k++) coef_q[k] <= rd[k];
    end
  end

  assign coef_b0 = coef_q[0];
  assign coef_b1 = coef_q[1];
  assign coef_b2 = coef_q[2];
  assign coef_a1 = coef_q[3];
  assign coef_a2 = coef_q[4];

endmodule

// File: tb/tb_coef_bank_writer.sv
// Directed bench for coef_bank_writer: bursts, aborts, tick-gated outputs and mid-burst reset.
module tb_coef_bank_writer;

  logic        clk;
  logic        reset_n;
  logic        sample_tick;
  logic [1:0]  sel;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_bank;
  logic [21:0] wr_data;
  logic        wr_last;
  logic [21:0] coef_b0, coef_b1, coef_b2, coef_a1, coef_a2;
  logic [1:0]  bank_active;
  logic        busy;
  logic        load_done;
  logic        load_err;

  int n_cmp = 0;
  int n_err = 0;

  coef_bank_writer #(.WIDTH(22)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sample_tick(sample_tick),
    .sel        (sel),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_bank    (wr_bank),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .coef_b0    (coef_b0),
    .coef_b1    (coef_b1),
    .coef_b2    (coef_b2),
    .coef_a1    (coef_a1),
    .coef_a2    (coef_a2),
    .bank_active(bank_active),
    .busy       (busy),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] bank, input logic [21:0] data, input logic last);
    wr_valid = 1'b1;
    wr_bank  = bank;
    wr_data  = data;
    wr_last  = last;
    step();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic tick(input logic [1:0] s);
    sel         = s;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  task automatic check_coefs(input string tag, input logic [21:0] e0, input logic [21:0] e1,
                             input logic [21:0] e2, input logic [21:0] e3, input logic [21:0] e4);
    check({tag, ".b0"}, 32'(coef_b0), 32'(e0));
    check({tag, ".b1"}, 32'(coef_b1), 32'(e1));
    check({tag, ".b2"}, 32'(coef_b2), 32'(e2));
    check({tag, ".a1"}, 32'(coef_a1), 32'(e3));
    check({tag, ".a2"}, 32'(coef_a2), 32'(e4));
  endtask

  initial begin
    reset_n     = 1'b0;
    sample_tick = 1'b0;
    sel         = 2'b00;
    wr_valid    = 1'b0;
    wr_bank     = 2'b00;
    wr_data     = '0;
    wr_last     = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // reset state
    check("rst.wr_ready", 32'(wr_ready), 32'd1);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.load_done", 32'(load_done), 32'd0);
    check("rst.load_err", 32'(load_err), 32'd0);
    check("rst.bank_active", 32'(bank_active), 32'd0);
    check_coefs("rst", 22'h0, 22'h0, 22'h0, 22'h0, 22'h0);

    // reset bank contents through the tick path
    tick(2'b01);
    check_coefs("rst_bank1", 22'h003FDF, 22'h0, 22'h0, 22'h0, 22'h0);
    check("rst_bank1.active", 32'(bank_active), 32'd1);
    tick(2'b11);
    check("rst_bank3.b0", 32'(coef_b0), 32'h002672);
    check("rst_bank3.active", 32'(bank_active), 32'd3);
    tick(2'b10);
    check("rst_bank2.b0", 32'(coef_b0), 32'h004000);

    // burst to bank 2 with gaps after beats 2 and 3
    beat(2'b10, 22'd1, 1'b0);
    check("b2.busy_after_beat1", 32'(busy), 32'd1);
    check("b2.ready_in_load", 32'(wr_ready), 32'd1);
    beat(2'b00, 22'd2, 1'b0);
    step();
    step();
    beat(2'b00, 22'd3, 1'b0);
    step();
    check("b2.gap_no_err", 32'(load_err), 32'd0);
    beat(2'b00, 22'd4, 1'b0);
    beat(2'b00, 22'd5, 1'b1);
    check("b2.load_done", 32'(load_done), 32'd1);
    check("b2.ready_in_commit", 32'(wr_ready), 32'd0);
    check("b2.busy_in_commit", 32'(busy), 32'd1);
    step();
    check("b2.load_done_pulse", 32'(load_done), 32'd0);
    check("b2.busy_idle", 32'(busy), 32'd0);
    check("b2.hold_before_tick", 32'(coef_b0), 32'h004000);
    tick(2'b10);
    check_coefs("b2.after_tick", 22'd1, 22'd2, 22'd3, 22'd4, 22'd5);

    // early wr_last on beat 3 aborts
    beat(2'b10, 22'h99, 1'b0);
    beat(2'b10, 22'h99, 1'b0);
    beat(2'b10, 22'h99, 1'b1);
    check("early.load_err", 32'(load_err), 32'd1);
    check("early.idle", 32'(busy), 32'd0);
    check("early.no_done", 32'(load_done), 32'd0);
    step();
    check("early.err_pulse", 32'(load_err), 32'd0);
    tick(2'b10);
    check_coefs("early.unchanged", 22'd1, 22'd2, 22'd3, 22'd4, 22'd5);

    // burst to bank 0 is consumed then rejected
    for (int i = 0; i < 5; i++) beat(2'b00, 22'h7, (i == 4));
    check("bank0.load_err", 32'(load_err), 32'd1);
    check("bank0.no_done", 32'(load_done), 32'd0);
    check("bank0.idle", 32'(busy), 32'd0);
    tick(2'b00);
    check_coefs("bank0.zero", 22'h0, 22'h0, 22'h0, 22'h0, 22'h0);
    check("bank0.active", 32'(bank_active), 32'd0);

    // wr_last on the very first beat
    beat(2'b01, 22'h55, 1'b1);
    check("first_last.load_err", 32'(load_err), 32'd1);
    check("first_last.idle", 32'(busy), 32'd0);

    // missing wr_last on beat 5
    for (int i = 0; i < 5; i++) beat(2'b01, 22'h66, 1'b0);
    check("no_last.load_err", 32'(load_err), 32'd1);
    check("no_last.idle", 32'(busy), 32'd0);
    tick(2'b01);
    check_coefs("no_last.bank1", 22'h003FDF, 22'h0, 22'h0, 22'h0, 22'h0);

    // commit to bank 1 on the same edge as a tick
    for (int i = 0; i < 5; i++) beat(2'b01, 22'h11 + 22'(i), (i == 4));
    check("same.in_commit", 32'(load_done), 32'd1);
    tick(2'b01);
    check_coefs("same.old", 22'h003FDF, 22'h0, 22'h0, 22'h0, 22'h0);
    tick(2'b01);
    check_coefs("same.new", 22'h11, 22'h12, 22'h13, 22'h14, 22'h15);

    // reset mid-burst to bank 3
    beat(2'b11, 22'h3A, 1'b0);
    beat(2'b11, 22'h3B, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_coefs("midrst", 22'h0, 22'h0, 22'h0, 22'h0, 22'h0);
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.active", 32'(bank_active), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    check("midrst.ready", 32'(wr_ready), 32'd1);
    tick(2'b11);
    check_coefs("midrst.bank3", 22'h002672, 22'h0, 22'h0, 22'h0, 22'h0);
    tick(2'b01);
    check_coefs("midrst.bank1", 22'h003FDF, 22'h0, 22'h0, 22'h0, 22'h0);
    tick(2'b10);
    check_coefs("midrst.bank2", 22'h004000, 22'h0, 22'h0, 22'h0, 22'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/coef_bank_writer.md
# coef_bank_writer

Writable coefficient store for the recursive (IIR) filter. It accepts a five-word burst (b0, b1, b2, a1, a2) over a valid/ready port into a shadow bank, then commits the burst atomically to one of three live banks. The active bank's coefficients go to the filter datapath, and changes take effect only on sample boundaries. It is the write-side counterpart of the fixed coefficient selectors: the same 2-bit band select and the same fixed-point format (Q7.14, 22 bits, 1.0 = 22'h004000), with bank contents loadable at run time.

## Interface
- width, 22, coefficient word width, two's-complement Q7.14.
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- sample_tick  in  1  one-cycle pulse marking a filter sample boundary.
- sel  in  2  band select: 00 bypass (all zero), 01 low, 10 mid, 11 high.
- wr_valid  in  1  write beat valid.
- wr_ready  out  1  writer can accept a beat.
- wr_bank  in  2  target bank, sampled on the first beat of a burst.
- wr_data  in  width  coefficient word.
- wr_last  in  1  marks the fifth (a2) beat.
- coef_b0, coef_b1, coef_b2, coef_a1, coef_a2  out  width each  active coefficients, registered.
- bank_active  out  2  bank currently driving the coef_* outputs.
- busy  out  1  burst in progress or commit pending.
- load_done  out  1  one-cycle pulse when a commit completes.
- load_err  out  1  one-cycle pulse when a burst is aborted.

## Operation
- Storage: live banks 1..3 of five words each, plus one five-word shadow. Bank 0 is not stored and always reads as zero.
- Reset contents of b0: bank1 22'h003FDF (0.998), bank2 22'h004000 (1.0), bank3 22'h002672 (0.6007). All other live words and the shadow reset to 0.
- States:
  - IDLE: waits for a beat.
  - LOAD: counts the beat index 0..4.
  - COMMIT: a single cycle that copies the shadow into the live bank.
- Beat accepted = wr_valid && wr_ready. Writes go to shadow[idx] in the order b0, b1, b2, a1, a2.
- IDLE → LOAD on the first accepted beat. That beat writes shadow[0], latches wr_bank, and sets idx to 1.
- LOAD → COMMIT on an accepted beat at idx 4 with wr_last=1.
- Abort: load_err pulses, the shadow is discarded, no live bank changes, and the FSM returns to IDLE. Causes:
  - wr_last=1 at idx<4.
  - wr_last=0 at idx 4.
  - latched wr_bank=00; the burst is still consumed to the abort point.
- If wr_last=1 on the very first beat, the burst aborts in IDLE and the FSM stays in IDLE.
- COMMIT → IDLE: all five live words of the latched bank update together, and load_done pulses that cycle.
- wr_ready is 1 in IDLE and LOAD, and 0 in COMMIT.
- busy is 1 in LOAD and COMMIT.
- Output update happens only on a cycle with sample_tick=1. That cycle:
  - samples sel into bank_active;
  - loads coef_* from the live bank sel (zeros for 00).
- Between ticks the outputs hold, even if sel changes or a commit rewrites the active bank. New contents appear on the next tick.
- Tick and commit in the same cycle: the outputs take the pre-commit live values; the committed values appear on the following tick.

## Timing
- Reset (asynchronous assert, synchronous release): FSM IDLE, idx 0, wr_ready 1 from the first cycle after release, busy 0, load_done 0, load_err 0, bank_active 00, all coef_* 0.
- Outputs register on the clk edge where sample_tick=1 and are valid the next cycle, i.e. 1-cycle latency from the tick.
- A burst with back-to-back beats takes 5 cycles, plus 1 cycle of COMMIT. load_done is high in the 6th cycle after the first beat, and the next burst can begin in the 7th cycle.
- Gaps (wr_valid=0) inside a burst are allowed, unbounded, and do not abort.
- load_err is asserted in the cycle after the offending beat.
- reset_n asserted mid-burst or mid-COMMIT: the shadow is lost and all live banks return to their reset values.

## Test plan
- Reset, then sel=01, one sample_tick → coef_b0=22'h003FDF, other coef_* 0, bank_active=01; sel=11 plus tick → coef_b0=22'h002672.
- Burst to bank 2 with data 1..5 (wr_last on beat 5), sel=10 → load_done one pulse; next tick coef_b0..a2 = 1,2,3,4,5; no change before the tick.
- Burst with wr_last on beat 3 → load_err pulse, FSM IDLE; bank contents unchanged on the next tick.
- Burst with wr_bank=00 → load_err; sel=00 plus tick keeps all coef_* 0.
- Commit to bank 1 in the same cycle as a tick with sel=01 → old values after this tick, new values after the next tick.
- reset_n low after beat 2 of a burst to bank 3 → outputs 0; after release, sel=11 plus tick → coef_b0=22'h002672.
